instr_queue: RTL and testbench
==============================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter width, default 32, bit width of the pc and instruction fields.
REQ-002 SHALL have parameter size, default 8, entry count; legal range 2..64, not restricted to powers of two.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all entries (branch mispredict).
REQ-006 SHALL have port enqueue  input  1  fetch presents a valid instruction this cycle.
REQ-007 SHALL have port data_i  input  pci_t  fetched pc and instruction.
REQ-008 SHALL have port dequeue  input  1  ROB takes the front entry; driven by the ROB's instr_q_dequeue.
REQ-009 SHALL have port data_o  output  pci_t  front entry (show-ahead); drives the ROB's instr_q_data.
REQ-010 SHALL have port empty  output  1  no valid entry; drives the ROB's instr_q_empty.
REQ-011 SHALL have port full  output  1  count equals size.
REQ-012 SHALL have port count  output  $clog2(size+1)  occupied entries.

Function
REQ-013 SHALL keep a circular buffer with front and rear indices, each $clog2(size) bits, plus a count register; full and empty SHALL derive from count only.
REQ-014 SHALL present data_o combinationally from the front entry; data_o is don't-care while empty.
REQ-015 SHALL write data_i at the rear index and increment rear on an accepted enqueue; the write is visible on data_o the next cycle at the earliest.
REQ-016 SHALL increment front on an accepted dequeue; the next entry appears on data_o in the following cycle.
REQ-017 SHALL wrap each index from size-1 to 0 by explicit compare, not by modulo of a power of two.
REQ-018 SHALL ignore enqueue while full, unless dequeue is asserted the same cycle; then both occur and count stays at size.
REQ-019 SHALL ignore dequeue while empty, and SHALL leave front and count unchanged.
REQ-020 SHALL, on simultaneous accepted enqueue and dequeue, advance both indices and leave count unchanged.
REQ-021 SHALL give flush priority over enqueue and dequeue: front=0, rear=0, count=0 next cycle, and the same-cycle enqueue is dropped.
REQ-022 SHALL NOT clear entry storage on dequeue or flush; only the indices and count move.

Reset
REQ-023 SHALL, on rst assertion and independent of clk, set front=0, rear=0, count=0, empty=1, full=0.
REQ-024 SHALL discard any in-flight operation on reset mid-stream; the first enqueue after deassertion SHALL land in entry 0.

Configuration
REQ-025 SHALL, with INSTR_Q_BYPASS_EN defined, pass data_i straight to data_o when empty, enqueue=1, dequeue=1 and flush=0, with no storage write and no index or count change; empty SHALL read 0 in that case.
REQ-026 SHALL, without INSTR_Q_BYPASS_EN, treat that case as enqueue-only per REQ-019: the entry is stored, and count becomes 1.

Structure
REQ-027 SHALL take pci_t (pc[width-1:0], instr[width-1:0]) from the shared package rv32i_types, which also holds rob_t and sal_t.
REQ-028 SHALL be a single module with no sub-modules; the storage is an unpacked array of pci_t.

Verification
REQ-029 SHALL cover: 8 enqueues of pc 0x100..0x11C from reset -> full=1, count=8, data_o.pc=0x100; a 9th enqueue -> ignored.
REQ-030 SHALL cover: while full, enqueue pc 0x200 plus dequeue -> count stays 8, front pc becomes 0x104, and 0x200 is stored in entry 0 (wrap).
REQ-031 SHALL cover: dequeue with empty=1 -> count=0 and indices unchanged; then 1 enqueue -> data_o.pc equals the enqueued pc next cycle.
REQ-032 SHALL cover: 5 entries, flush plus enqueue same cycle -> count=0, empty=1 next cycle; the next enqueue appears as data_o.
REQ-033 SHALL cover: rst asserted mid-cycle with count=3 -> empty=1 immediately without a clock edge.
REQ-034 SHALL cover, with INSTR_Q_BYPASS_EN: empty with enqueue=dequeue=1 and pc 0x300 -> data_o.pc=0x300 that cycle and count stays 0; without the macro -> count=1.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared rv32i pipeline types: fetch pc/instruction pair, ROB and store-address entries
package rv32i_types;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } pci_t;

    typedef struct packed {
        logic            valid;
        logic            ready;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] value;
    } rob_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [3:0]      mask;
    } sal_t;

endpackage

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - fetch-to-ROB circular instruction queue, show-ahead front; optional INSTR_Q_BYPASS_EN empty-queue pass-through
module instr_queue
    import rv32i_types::*;
#(
    parameter int width = 32,
    parameter int size  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      enqueue,
    input  pci_t                      data_i,
    input  logic                      dequeue,
    output pci_t                      data_o,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(size+1)-1:0] count
);

    localparam int IDX_W = $clog2(size);
    localparam int CNT_W = $clog2(size+1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(size - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(size);

    // pci_t is sized by the shared package, so the field width parameter must agree with it
    if (width != XLEN) begin : g_width_check
        $error("instr_queue: width must equal rv32i_types::XLEN");
    end

    pci_t             mem_q [size];
    logic [IDX_W-1:0] front_q, front_d;
    logic [IDX_W-1:0] rear_q,  rear_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic q_empty;
    logic q_full;
    logic bypass;
    logic do_enq;
    logic do_deq;
    logic wr_en;

    assign q_empty = (count_q == '0);
    assign q_full  = (count_q == FULL_CNT);

`ifdef INSTR_Q_BYPASS_EN
    assign bypass = q_empty && enqueue && dequeue && !flush;
`else
    assign bypass = 1'b0;
`endif

    // acceptance: a full queue still takes a write when the front leaves in the same cycle
    always_comb begin
        do_enq = 1'b0;
        do_deq = 1'b0;
        if (!flush && !bypass) begin
            do_deq = dequeue && !q_empty;
            do_enq = enqueue && (!q_full || dequeue);
        end
    end

    assign wr_en = do_enq;

    // next-state for indices and occupancy; flush clears everything and drops the same-cycle write
    always_comb begin
        front_d = front_q;
        rear_d  = rear_q;
        count_d = count_q;
        if (flush) begin
            front_d = '0;
            rear_d  = '0;
            count_d = '0;
        end else begin
            if (do_deq) begin
                front_d = (front_q == LAST_IDX) ? '0 : front_q + IDX_W'(1);
            end
            if (do_enq) begin
                rear_d = (rear_q == LAST_IDX) ? '0 : rear_q + IDX_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // index and count registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_q <= '0;
            rear_q  <= '0;
            count_q <= '0;
        end else begin
            front_q <= front_d;
            rear_q  <= rear_d;
            count_q <= count_d;
        end
    end

    // entry storage is never cleared; only the indices decide what is live
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[rear_q] <= data_i;
        end
    end

    assign data_o = bypass ? data_i : mem_q[front_q];
    assign empty  = q_empty && !bypass;
    assign full   = q_full;
    assign count  = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - scoreboard testbench for instr_queue (build with or without INSTR_Q_BYPASS_EN)
module tb_instr_queue;
    import rv32i_types::*;

    localparam int SIZE = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       enqueue = 1'b0;
    logic       dequeue = 1'b0;
    pci_t       data_i = '0;
    pci_t       data_o;
    logic       empty;
    logic       full;
    logic [3:0] count;

    instr_queue #(.width(32), .size(SIZE)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .enqueue (enqueue),
        .data_i  (data_i),
        .dequeue (dequeue),
        .data_o  (data_o),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    always #5 clk = ~clk;

    typedef enum int {F_COUNT, F_EMPTY, F_FULL, F_PC} field_e;

    typedef struct {
        string       name;
        field_e      field;
        logic [31:0] exp;
    } chk_t;

    chk_t chk_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic expect_now(input string name, input field_e f, input logic [31:0] v);
        chk_t c;
        c.name  = name;
        c.field = f;
        c.exp   = v;
        chk_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic e, input logic d, input logic f, input logic [31:0] pc);
        enqueue   = e;
        dequeue   = d;
        flush     = f;
        data_i.pc = pc;
        data_i.instr = pc ^ 32'hA5A5_0000;
    endtask

    // monitor: drain pending expectations against the DUT away from the clock edge
    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c = chk_q.pop_front();
            case (c.field)
                F_COUNT: act = 32'(count);
                F_EMPTY: act = 32'(empty);
                F_FULL:  act = 32'(full);
                default: act = data_o.pc;
            endcase
            n_chk++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        set_in(0, 0, 0, 0);
        expect_now("reset_count", F_COUNT, 0);
        expect_now("reset_empty", F_EMPTY, 1);
        expect_now("reset_full",  F_FULL,  0);
        tick();
        tick();
        rst = 1'b0;

        // fill with 8 entries
        for (int i = 0; i < SIZE; i++) begin
            set_in(1, 0, 0, 32'h100 + 32'(i * 4));
            tick();
        end
        set_in(0, 0, 0, 0);
        expect_now("fill_full",  F_FULL,  1);
        expect_now("fill_count", F_COUNT, 8);
        expect_now("fill_front", F_PC,    32'h100);
        tick();

        // 9th enqueue ignored
        set_in(1, 0, 0, 32'h120);
        tick();
        set_in(0, 0, 0, 0);
        expect_now("ovf_count", F_COUNT, 8);
        expect_now("ovf_front", F_PC,    32'h100);
        tick();

        // enqueue + dequeue while full
        set_in(1, 1, 0, 32'h200);
        expect_now("full_rw_front", F_PC, 32'h100);
        tick();
        set_in(0, 0, 0, 0);
        expect_now("full_rw_count", F_COUNT, 8);
        expect_now("full_rw_next",  F_PC,    32'h104);
        tick();

        // drain old entries, wrapped 0x200 must surface last
        for (int i = 1; i < SIZE; i++) begin
            set_in(0, 1, 0, 0);
            expect_now("drain_pc", F_PC, 32'h100 + 32'(i * 4));
            tick();
        end
        set_in(0, 0, 0, 0);
        expect_now("wrap_count", F_COUNT, 1);
        expect_now("wrap_pc",    F_PC,    32'h200);
        tick();
        set_in(0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0);
        expect_now("drained_empty", F_EMPTY, 1);
        tick();

        // dequeue while empty ignored
        set_in(0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0);
        expect_now("deq_empty_count", F_COUNT, 0);
        expect_now("deq_empty_empty", F_EMPTY, 1);
        tick();
        set_in(1, 0, 0, 32'h400);
        tick();
        set_in(0, 0, 0, 0);
        expect_now("after_empty_pc",    F_PC,    32'h400);
        expect_now("after_empty_count", F_COUNT, 1);
        tick();

        // five entries then flush with a same-cycle enqueue
        for (int i = 1; i < 5; i++) begin
            set_in(1, 0, 0, 32'h400 + 32'(i * 4));
            tick();
        end
        set_in(0, 0, 0, 0);
        expect_now("pre_flush_count", F_COUNT, 5);
        tick();
        set_in(1, 0, 1, 32'h500);
        tick();
        set_in(0, 0, 0, 0);
        expect_now("flush_count", F_COUNT, 0);
        expect_now("flush_empty", F_EMPTY, 1);
        tick();
        set_in(1, 0, 0, 32'h600);
        tick();
        set_in(0, 0, 0, 0);
        expect_now("post_flush_pc",    F_PC,    32'h600);
        expect_now("post_flush_empty", F_EMPTY, 0);
        tick();

        // asynchronous reset mid-cycle with three entries
        set_in(1, 0, 0, 32'h604);
        tick();
        set_in(1, 0, 0, 32'h608);
        tick();
        set_in(0, 0, 0, 0);
        expect_now("pre_rst_count", F_COUNT, 3);
        tick();
        #2;
        rst = 1'b1;
        expect_now("async_rst_empty", F_EMPTY, 1);
        expect_now("async_rst_count", F_COUNT, 0);
        tick();
        rst = 1'b0;
        set_in(1, 0, 0, 32'h700);
        tick();
        set_in(0, 0, 0, 0);
        expect_now("post_rst_pc",    F_PC,    32'h700);
        expect_now("post_rst_count", F_COUNT, 1);
        tick();
        set_in(0, 1, 0, 0);
        tick();

        // empty queue with enqueue and dequeue together
        set_in(1, 1, 0, 32'h300);
`ifdef INSTR_Q_BYPASS_EN
        expect_now("bypass_pc",    F_PC,    32'h300);
        expect_now("bypass_empty", F_EMPTY, 0);
        tick();
        set_in(0, 0, 0, 0);
        expect_now("bypass_count", F_COUNT, 0);
        expect_now("bypass_after", F_EMPTY, 1);
`else
        expect_now("nobypass_empty", F_EMPTY, 1);
        tick();
        set_in(0, 0, 0, 0);
        expect_now("nobypass_count", F_COUNT, 1);
        expect_now("nobypass_pc",    F_PC,    32'h300);
`endif
        tick();
        tick();

        n_chk++;
        if (chk_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", chk_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
